// File: rtl/egress_port_rx.sv
// -----------------------------------------------------------------------------
// egress_port_rx
//
// Receive side of one switch egress port.
// - Asks the switch read port for one packet at a time with a single-cycle
//   ready pulse.
// - Latches the control word: len L = [15:7], prio = [6:4], dest = [3:0].
// - Forwards the payload words with one cycle of latency.
// - Closes each packet with a pkt_done pulse plus an error classification.
//
// Optional feature: define RX_PAYLOAD_CHECK_EN to compare payload word k
// against k[15:0]. Any mismatch is then reported as err_code 3, unless a
// higher-priority error applies.
//
// Parameters
//   PORT_ID   egress port index (0..3) this receiver serves
//   GAP_CYC   idle cycles between a packet close and the next ready request
//   TIMEOUT   cycles to wait for rd_sop after a ready pulse
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   enable              permits new ready requests (never aborts a packet)
//   rd_sop/eop/vld      packet start / end / word-valid from the read port
//   rd_data[15:0]       read word
//   ready               single-cycle request for one packet
//   out_vld, out_data   forwarded payload words (control word excluded)
//   pkt_done            single-cycle pulse when a packet closes
//   pkt_err, err_code   with pkt_done: 0 ok, 1 length, 2 dest, 3 payload
//   pkt_len, pkt_prio   L and prio of the last packet closed from DATA
//   pkt_cnt/err_cnt/to_cnt  saturating good / errored / timeout counters
//   dbg_state           current FSM state
//
// Read-port handshake: ready is a one-cycle request. The switch answers with
// rd_sop. Words qualified by rd_vld follow in later cycles: the first one is
// the control word, then come L+1 payload words. rd_eop arrives with
// rd_vld=0 in the cycle after the last word. There is no backpressure: every
// rd_vld word is consumed in the cycle it is presented.
// -----------------------------------------------------------------------------
module egress_port_rx #(
    parameter int PORT_ID = 0,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rd_sop,
    input  logic        rd_eop,
    input  logic        rd_vld,
    input  logic [15:0] rd_data,
    output logic        ready,
    output logic        out_vld,
    output logic [15:0] out_data,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic [8:0]  pkt_len,
    output logic [2:0]  pkt_prio,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] to_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_SOP = 3'd2,
        HDR      = 3'd3,
        DATA     = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam logic [3:0]  PORT_DEST = 4'(PORT_ID);
    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    // Payload counter sticks one past the largest legal packet (512 words).
    // Any count this high can never equal L+1.
    localparam logic [9:0]  K_SAT     = 10'd513;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] gap_q, gap_d;
    logic [9:0]  k_q, k_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic        out_vld_q, out_vld_d;
    logic [15:0] out_data_q, out_data_d;
    logic        done_q, perr_q;
    logic [1:0]  code_q;
    logic [8:0]  len_q;
    logic [2:0]  prio_q;
    logic [15:0] pkt_cnt_q, err_cnt_q, to_cnt_q;

    logic        close;        // a packet closes this cycle
    logic        close_data;   // ... and its control word is valid
    logic [1:0]  close_code;
    logic        timeout;
    logic [1:0]  data_code;    // classification of a normal eop close
    logic        pay_mis;

`ifdef RX_PAYLOAD_CHECK_EN
    logic pay_err_q, pay_err_d;
    assign pay_mis = pay_err_q;
`else
    assign pay_mis = 1'b0;
`endif

    always_comb begin
        data_code = 2'd0;
        if (ctrl_q[3:0] != PORT_DEST) begin
            data_code = 2'd2;
        end else if (k_q != ({1'b0, ctrl_q[15:7]} + 10'd1)) begin
            data_code = 2'd1;
        end else if (pay_mis) begin
            data_code = 2'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        gap_d      = gap_q;
        k_d        = k_q;
        ctrl_d     = ctrl_q;
        out_vld_d  = 1'b0;
        out_data_d = out_data_q;
        close      = 1'b0;
        close_data = 1'b0;
        close_code = 2'd0;
        timeout    = 1'b0;
`ifdef RX_PAYLOAD_CHECK_EN
        pay_err_d  = pay_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) state_d = REQ;
            end
            REQ: begin
                wait_d  = 16'd0;
                state_d = WAIT_SOP;
            end
            WAIT_SOP: begin
                if (rd_sop) begin
                    state_d = HDR;
                end else if (wait_q + 16'd1 == TO_LIM) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            HDR: begin
                // The control word has not arrived yet, so pkt_len/pkt_prio
                // keep describing the previous packet on these closes.
                if (rd_sop) begin
                    close      = 1'b1;
                    close_code = 2'd1;
                end else if (rd_eop) begin
                    close      = 1'b1;
                    close_code = 2'd1;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = 16'd0;
                    end
                end else if (rd_vld) begin
                    ctrl_d  = rd_data;
                    k_d     = 10'd0;
                    state_d = DATA;
`ifdef RX_PAYLOAD_CHECK_EN
                    pay_err_d = 1'b0;
`endif
                end
            end
            DATA: begin
                if (rd_sop) begin
                    // A new start cuts the current packet short.
                    close      = 1'b1;
                    close_data = 1'b1;
                    close_code = 2'd1;
                    state_d    = HDR;
                end else if (rd_eop) begin
                    close      = 1'b1;
                    close_data = 1'b1;
                    close_code = data_code;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = 16'd0;
                    end
                end else if (rd_vld) begin
                    out_vld_d  = 1'b1;
                    out_data_d = rd_data;
                    if (k_q != K_SAT) k_d = k_q + 10'd1;
`ifdef RX_PAYLOAD_CHECK_EN
                    if (rd_data != {6'd0, k_q}) pay_err_d = 1'b1;
`endif
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= 16'd0;
            gap_q      <= 16'd0;
            k_q        <= 10'd0;
            ctrl_q     <= 16'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= 16'd0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            code_q     <= 2'd0;
            len_q      <= 9'd0;
            prio_q     <= 3'd0;
            pkt_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
            to_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            k_q        <= k_d;
            ctrl_q     <= ctrl_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            done_q     <= close;
            perr_q     <= close && (close_code != 2'd0);
            if (close) code_q <= close_code;
            if (close_data) begin
                len_q  <= ctrl_q[15:7];
                prio_q <= ctrl_q[6:4];
            end
            if (close && (close_code == 2'd0) && (pkt_cnt_q != 16'hFFFF))
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (close && (close_code != 2'd0) && (err_cnt_q != 16'hFFFF))
                err_cnt_q <= err_cnt_q + 16'd1;
            if (timeout && (to_cnt_q != 16'hFFFF))
                to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

`ifdef RX_PAYLOAD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pay_err_q <= 1'b0;
        else        pay_err_q <= pay_err_d;
    end
`endif

    assign ready     = (state_q == REQ);
    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign pkt_done  = done_q;
    assign pkt_err   = perr_q;
    assign err_code  = code_q;
    assign pkt_len   = len_q;
    assign pkt_prio  = prio_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign to_cnt    = to_cnt_q;
    assign dbg_state = state_q;

endmodule
